hoene_firsttry: RTL and testbench

HOENE_FIRSTTRY -- requirements
Module: hoene_firsttry

---
 rtl/hoene_firsttry.sv | 112 +++++++++++
 tb/tb_hoene_firsttry.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hoene_firsttry.sv
// Three-channel 10-bit PWM colour driver plus a one-shot input selector FSM.
// rst_n is an active-high asynchronous reset despite its name.
module hoene_firsttry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, SEL0, SEL1} sel_state_t;

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic       strobe_prev;
  logic       in0_s;
  logic       in1_s;
  logic       testmode_s;
  logic       write_pulse;

  sel_state_t state;
  logic       sel_out;

  logic [9:0] red;
  logic [9:0] green;
  logic [9:0] blue;
  logic [9:0] counter;
  logic [2:0] pwm;

  logic       unused_ok;

  assign unused_ok = &{1'b0, ena};

  // Bits 0..3 of ui_in are asynchronous; strobe edge detection uses the synced copy.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      strobe_prev <= 1'b0;
    end else begin
      sync1       <= ui_in[3:0];
      sync2       <= sync1;
      strobe_prev <= sync2[3];
    end
  end

  assign in0_s       = sync2[0];
  assign in1_s       = sync2[1];
  assign testmode_s  = sync2[2];
  assign write_pulse = sync2[3] & ~strobe_prev;

  // The first decision out of IDLE sticks until the next reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      sel_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel_out <= 1'b0;
          if (testmode_s || in0_s) begin
            state <= SEL0;
          end else if (in1_s) begin
            state <= SEL1;
          end
        end
        SEL0: sel_out <= in0_s;
        SEL1: sel_out <= in1_s;
        default: begin
          state   <= IDLE;
          sel_out <= 1'b0;
        end
      endcase
    end
  end

  // Channel and data are sampled unsynchronised; the writer holds them stable around the strobe.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (write_pulse) begin
      case (ui_in[5:4])
        2'd0:    red   <= {ui_in[7:6], uio_in};
        2'd1:    green <= {ui_in[7:6], uio_in};
        2'd2:    blue  <= {ui_in[7:6], uio_in};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      counter <= '0;
      pwm     <= '0;
    end else begin
      counter <= counter + 10'd1;
      pwm[0]  <= (counter < red);
      pwm[1]  <= (counter < green);
      pwm[2]  <= (counter < blue);
    end
  end

  assign uo_out  = {3'b000, (state == SEL0), sel_out, pwm};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_hoene_firsttry.sv
// Directed self-checking bench for hoene_firsttry: selector FSM, colour writes, PWM duty, async reset.
module tb_hoene_firsttry;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       in0;
  logic       in1;
  logic       tm;
  logic       stb;
  logic [1:0] ch;
  logic [1:0] hi;

  int tests_run    = 0;
  int tests_failed = 0;
  int r_cnt;
  int g_cnt;
  int b_cnt;

  assign ui_in = {hi, ch, stb, tm, in1, in0};

  hoene_firsttry dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    in0    = 1'b0;
    in1    = 1'b0;
    tm     = 1'b0;
    stb    = 1'b0;
    ch     = 2'd0;
    hi     = 2'd0;
    uio_in = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Strobe pulse with channel/data held well past the synchroniser latency.
  task automatic write_colour(input logic [1:0] c, input logic [9:0] v);
    @(negedge clk);
    ch     = c;
    hi     = v[9:8];
    uio_in = v[7:0];
    stb    = 1'b1;
    repeat (6) @(negedge clk);
    stb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Count high cycles of each PWM output over one full 1024-clock period.
  task automatic measure(output int r, output int g, output int b);
    r = 0;
    g = 0;
    b = 0;
    repeat (1024) begin
      @(negedge clk);
      r += int'(uo_out[0]);
      g += int'(uo_out[1]);
      b += int'(uo_out[2]);
    end
  endtask

  task automatic apply_stimulus();
    // Reset state
    rst_n = 1'b1;
    ena   = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    check_output("reset_uo_out", 16'(uo_out), 16'h0000);
    check_output("reset_uio_out", 16'(uio_out), 16'h0000);
    check_output("reset_uio_oe", 16'(uio_oe), 16'h0000);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("idle_uo_out", 16'(uo_out), 16'h0000);

    // in1 alone selects SEL1; a later in0 pulse is ignored
    ena = 1'b0;
    in1 = 1'b1;
    repeat (5) @(negedge clk);
    check_output("sel1_in0selected", 16'(uo_out[4]), 16'd0);
    check_output("sel1_out_high", 16'(uo_out[3]), 16'd1);
    in1 = 1'b0;
    repeat (4) @(negedge clk);
    check_output("sel1_out_low", 16'(uo_out[3]), 16'd0);
    in0 = 1'b1;
    repeat (5) @(negedge clk);
    check_output("sel1_in0_ignored_sel", 16'(uo_out[4]), 16'd0);
    check_output("sel1_in0_ignored_out", 16'(uo_out[3]), 16'd0);
    in0 = 1'b0;
    in1 = 1'b1;
    repeat (4) @(negedge clk);
    check_output("sel1_follows_again", 16'(uo_out[3]), 16'd1);

    // Simultaneous in0/in1 prefers SEL0
    do_reset();
    @(negedge clk);
    in0 = 1'b1;
    in1 = 1'b1;
    repeat (5) @(negedge clk);
    check_output("both_in0selected", 16'(uo_out[4]), 16'd1);
    check_output("both_out_high", 16'(uo_out[3]), 16'd1);
    in0 = 1'b0;
    repeat (4) @(negedge clk);
    check_output("both_follows_in0", 16'(uo_out[3]), 16'd0);

    // Testmode forces SEL0 while in1 toggles
    do_reset();
    @(negedge clk);
    tm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in1 = ~in1;
      @(negedge clk);
    end
    check_output("tm_in0selected", 16'(uo_out[4]), 16'd1);
    check_output("tm_out_low", 16'(uo_out[3]), 16'd0);
    in0 = 1'b1;
    repeat (4) @(negedge clk);
    check_output("tm_follows_in0", 16'(uo_out[3]), 16'd1);

    // Colour writes and PWM duty
    do_reset();
    write_colour(2'd0, 10'd256);
    measure(r_cnt, g_cnt, b_cnt);
    check_output("red256_r", 16'(r_cnt), 16'd256);
    check_output("red256_g", 16'(g_cnt), 16'd0);
    check_output("red256_b", 16'(b_cnt), 16'd0);

    write_colour(2'd2, 10'd1023);
    measure(r_cnt, g_cnt, b_cnt);
    check_output("blue1023_b", 16'(b_cnt), 16'd1023);
    check_output("blue1023_r", 16'(r_cnt), 16'd256);

    write_colour(2'd2, 10'd0);
    measure(r_cnt, g_cnt, b_cnt);
    check_output("blue0_b", 16'(b_cnt), 16'd0);

    write_colour(2'd1, 10'd100);
    measure(r_cnt, g_cnt, b_cnt);
    check_output("green100_g", 16'(g_cnt), 16'd100);

    write_colour(2'd3, 10'd500);
    measure(r_cnt, g_cnt, b_cnt);
    check_output("ch3_r", 16'(r_cnt), 16'd256);
    check_output("ch3_g", 16'(g_cnt), 16'd100);
    check_output("ch3_b", 16'(b_cnt), 16'd0);

    // Strobe held high: only the first rising edge writes
    @(negedge clk);
    ch     = 2'd0;
    hi     = 2'd1;
    uio_in = 8'd44;
    stb    = 1'b1;
    repeat (8) @(negedge clk);
    ch     = 2'd1;
    hi     = 2'd2;
    uio_in = 8'd188;
    repeat (8) @(negedge clk);
    measure(r_cnt, g_cnt, b_cnt);
    check_output("held_r", 16'(r_cnt), 16'd300);
    check_output("held_g", 16'(g_cnt), 16'd100);
    stb = 1'b0;
    repeat (4) @(negedge clk);

    // Async reset mid-period with red=512
    write_colour(2'd0, 10'd512);
    measure(r_cnt, g_cnt, b_cnt);
    check_output("red512_r", 16'(r_cnt), 16'd512);
    for (int i = 0; i < 1100 && !uo_out[0]; i++) @(negedge clk);
    check_output("pre_reset_red_high", 16'(uo_out[0]), 16'd1);
    #2;
    rst_n = 1'b1;
    #1;
    check_output("async_reset_uo_out", 16'(uo_out), 16'h0000);
    @(negedge clk);
    clear_inputs();
    repeat (3) @(negedge clk);
    check_output("held_reset_uo_out", 16'(uo_out), 16'h0000);
    rst_n = 1'b0;
    measure(r_cnt, g_cnt, b_cnt);
    check_output("post_reset_r", 16'(r_cnt), 16'd0);
    check_output("post_reset_g", 16'(g_cnt), 16'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
